serial_full_adder: RTL and testbench

SERIAL_FULL_ADDER -- requirements
Module: serial_full_adder

---
 rtl/serial_full_adder.sv | 110 +++++++++++
 tb/tb_serial_full_adder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_full_adder.sv
// ============================================================================
// Module      : serial_full_adder
// Description : Bit-serial adder, one full-adder cell plus carry flop, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_full_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_psum;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_sum_bit;
    logic               w_carry_next;
    logic [WIDTH-1:0]   w_psum_next;
    logic               w_last;
    logic               w_accept;

    always_comb begin
        w_sum_bit    = r_a[0] ^ r_b[0] ^ r_carry;
        w_carry_next = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
        w_psum_next  = {w_sum_bit, r_psum[WIDTH-1:1]};
        w_last       = (r_cnt == c_LAST);
        w_accept     = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = start ? S_RUN : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            Sum     <= '0;
            Cout    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a     <= in1;
                r_b     <= in2;
                r_carry <= Cin;
                r_psum  <= '0;
                r_cnt   <= '0;
            end else if (r_state == S_RUN) begin
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_carry <= w_carry_next;
                r_psum  <= w_psum_next;
                r_cnt   <= r_cnt + c_ONE;
                // Publish on the final bit so the result is visible in the DONE cycle
                if (w_last) begin
                    Sum  <= w_psum_next;
                    Cout <= w_carry_next;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_full_adder.sv
// ============================================================================
// Module      : tb_serial_full_adder
// Description : Scoreboard bench for serial_full_adder at WIDTH 8 and 16.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_full_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start8, cin8, busy8, done8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        start16, cin16, busy16, done16, cout16;
    logic [15:0] a16, b16, sum16;

    int checks = 0;
    int errors = 0;
    int done_cnt8 = 0;
    logic [8:0]  sb8[$];
    logic [16:0] sb16[$];

    serial_full_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .in1(a8), .in2(b8), .Cin(cin8),
        .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8)
    );

    serial_full_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .in1(a16), .in2(b16), .Cin(cin16),
        .busy(busy16), .done(done16), .Sum(sum16), .Cout(cout16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop the scoreboard whenever a done pulse is presented
    always @(negedge clk) begin
        if (done8) begin
            done_cnt8++;
            check("busy_done_excl8", {31'd0, busy8}, 32'd0);
            if (sb8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done8: got result %0h expected no done", {cout8, sum8});
            end else begin
                check("result8", {23'd0, cout8, sum8}, {23'd0, sb8.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (done16) begin
            check("busy_done_excl16", {31'd0, busy16}, 32'd0);
            if (sb16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done16: got result %0h expected no done", {cout16, sum16});
            end else begin
                check("result16", {15'd0, cout16, sum16}, {15'd0, sb16.pop_front()});
            end
        end
    end

    // Drive a start with operands; caller is positioned just after a rising edge
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [8:0] exp, input bit push);
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        cin8 = c;
        if (push) sb8.push_back(exp);
        @(posedge clk);
        #1;
        start8 = 1'b0;
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic c);
        start16 = 1'b1;
        a16 = a;
        b16 = b;
        cin16 = c;
        sb16.push_back(17'(a) + 17'(b) + 17'(c));
        @(posedge clk);
        #1;
        start16 = 1'b0;
    endtask

    task automatic wait_done8(input bit hold_en, input logic [8:0] hold_val, output int busy_len);
        bit found = 1'b0;
        busy_len = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (done8) begin
                found = 1'b1;
                break;
            end
            if (busy8) begin
                busy_len++;
                if (hold_en) check("sum_hold_run8", {23'd0, cout8, sum8}, {23'd0, hold_val});
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL timeout8: got no done expected done within 64 cycles");
        end
    endtask

    task automatic wait_done16();
        bit found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (done16) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL timeout16: got no done expected done within 64 cycles");
        end
    endtask

    initial begin
        int len;
        int base;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_sum", {24'd0, sum8}, 32'd0);
        check("rst_cout", {31'd0, cout8}, 32'd0);
        check("rst_sum16", {15'd0, cout16, sum16}, 32'd0);

        // Start presented on the first edge after reset release
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue8(8'h0F, 8'h01, 1'b0, 9'h010, 1'b1);
        wait_done8(1'b1, 9'h000, len);
        check("busy_len_0F01", len, 32'd8);

        @(posedge clk);
        #1;
        issue8(8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
        wait_done8(1'b1, 9'h010, len);
        check("busy_len_FF01", len, 32'd8);

        @(posedge clk);
        #1;
        issue8(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b1);
        wait_done8(1'b1, 9'h100, len);

        // start held high with operands churning during RUN
        @(posedge clk);
        #1;
        base = done_cnt8;
        start8 = 1'b1; a8 = 8'h3C; b8 = 8'h05; cin8 = 1'b0;
        sb8.push_back(9'h041);
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            cin8 = 1'($urandom);
            @(negedge clk);
            check("sum_hold_churn", {23'd0, cout8, sum8}, 32'h1FF);
            @(posedge clk);
            #1;
        end
        start8 = 1'b0;
        wait_done8(1'b1, 9'h1FF, len);
        repeat (15) @(negedge clk);
        check("single_done_churn", done_cnt8 - base, 32'd1);

        // Reset in the 4th RUN cycle aborts silently
        @(posedge clk);
        #1;
        base = done_cnt8;
        issue8(8'h12, 8'h34, 1'b0, 9'h000, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_done", {31'd0, done8}, 32'd0);
        check("abort_sum", {24'd0, sum8}, 32'd0);
        check("abort_cout", {31'd0, cout8}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_no_done", done_cnt8 - base, 32'd0);

        // Back-to-back start taken in the DONE cycle
        @(posedge clk);
        #1;
        issue8(8'h01, 8'h02, 1'b0, 9'h003, 1'b1);
        wait_done8(1'b0, 9'h000, len);
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        sb8.push_back(9'h100);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        @(negedge clk);
        check("b2b_busy", {31'd0, busy8}, 32'd1);
        wait_done8(1'b1, 9'h003, len);
        check("b2b_busy_len", len, 32'd7);

        for (int i = 0; i < 600; i++) begin
            logic [7:0] ra, rb;
            logic rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            @(posedge clk);
            #1;
            issue8(ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc), 1'b1);
            wait_done8(1'b0, 9'h000, len);
        end

        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            issue16(16'($urandom), 16'($urandom), 1'($urandom));
            wait_done16();
        end

        repeat (3) @(negedge clk);
        check("sb8_drained", sb8.size(), 32'd0);
        check("sb16_drained", sb16.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
